// File: rtl/gcd_unit_8b.sv
// 8-bit GCD unit: subtract-and-swap Euclid behind a val/rdy operand stream and a val/rdy result stream.
// Holds the gate-level subtractor, the structural comparator and the three-state control.

module gcd_full_sub (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    logic axb;

    assign axb    = a_i ^ b_i;
    assign d_o    = axb ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~axb & bin_i);
endmodule

module Subtractor_8b_GL (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] diff_o,
    output logic       bout_o
);
    logic [8:0] borrow;

    assign borrow[0] = 1'b0;

    gcd_full_sub u_fs [7:0] (
        .a_i    (a_i),
        .b_i    (b_i),
        .bin_i  (borrow[7:0]),
        .d_o    (diff_o),
        .bout_o (borrow[8:1])
    );

    assign bout_o = borrow[8];
endmodule

// One bit of an LSB-to-MSB less-than chain: a decision at a higher bit overrides the lower bits.
module gcd_cmp_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic lt_i,
    output logic lt_o
);
    assign lt_o = (~a_i & b_i) | (~(a_i ^ b_i) & lt_i);
endmodule

module gcd_lt_cmp_8b (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic       lt_o
);
    logic [7:0] chain;

    gcd_cmp_cell u_cell [7:0] (
        .a_i  (a_i),
        .b_i  (b_i),
        .lt_i ({chain[6:0], 1'b0}),
        .lt_o (chain)
    );

    assign lt_o = chain[7];
endmodule

module gcd_unit_8b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       istream_val,
    output logic       istream_rdy,
    input  logic [7:0] istream_a,
    input  logic [7:0] istream_b,
    output logic       ostream_val,
    input  logic       ostream_rdy,
    output logic [7:0] ostream_result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;

    logic [7:0] sub_diff;
    logic       sub_bout;
    logic       a_lt_b;
    logic       b_nz;

    Subtractor_8b_GL u_sub (
        .a_i    (a_q),
        .b_i    (b_q),
        .diff_o (sub_diff),
        .bout_o (sub_bout)
    );

    gcd_lt_cmp_8b u_cmp (
        .a_i  (a_q),
        .b_i  (b_q),
        .lt_o (a_lt_b)
    );

    assign b_nz = |b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;

        case (state_q)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    a_d     = istream_a;
                    b_d     = istream_b;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (a_lt_b) begin
                    a_d = b_q;
                    b_d = a_q;
                end else if (b_nz) begin
                    // A>=B here, so borrow-out never fires; it only guards against a wrapped result.
                    if (!sub_bout) a_d = sub_diff;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ostream_result = a_q;
endmodule

// File: tb/tb_gcd_unit_8b.sv
// Scoreboarded bench for gcd_unit_8b: directed latency/boundary/stall/reset scenarios, then random backpressured traffic.
module tb_gcd_unit_8b;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       istream_val;
    logic       istream_rdy;
    logic [7:0] istream_a;
    logic [7:0] istream_b;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [7:0] ostream_result;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    gcd_unit_8b dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .istream_val    (istream_val),
        .istream_rdy    (istream_rdy),
        .istream_a      (istream_a),
        .istream_b      (istream_b),
        .ostream_val    (ostream_val),
        .ostream_rdy    (ostream_rdy),
        .ostream_result (ostream_result)
    );

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Drives one pair for a single cycle (cycle 0); returns whether it was accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, output bit hs);
        istream_a   = a;
        istream_b   = b;
        istream_val = 1'b1;
        @(negedge clk);
        hs = istream_rdy;
        if (hs) sb.push_back(ref_gcd(a, b));
        @(posedge clk); #1;
        istream_val = 1'b0;
    endtask

    // Counts cycles from 1 until ostream_val is seen; stops at that cycle's negedge.
    task automatic wait_result(input int budget, output int cyc, output bit timeout, output bit rdy_seen);
        bit done;
        done = 0; timeout = 0; rdy_seen = 0; cyc = 1;
        while (!done) begin
            @(negedge clk);
            if (ostream_val) done = 1;
            else begin
                if (istream_rdy) rdy_seen = 1;
                if (cyc >= budget) begin
                    timeout = 1;
                    done = 1;
                end else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ostream_rdy = 1'b1;
        istream_val = 1'b1; istream_a = 8'd5; istream_b = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", istream_rdy); end
        checks++;
        if (ostream_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", ostream_val); end
        checks++;
        if (ostream_result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", ostream_result); end
        istream_val = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_hs: got rdy=%b val=%b expected rdy=1 val=0", istream_rdy, ostream_val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency();
        bit hs, to, rs; int cyc; logic [7:0] exp;
        ostream_rdy = 1'b1;
        send(8'd12, 8'd8, hs);
        checks++;
        if (!hs) begin errors++; $display("FAIL lat_hs: got 0 expected 1"); end
        wait_result(20, cyc, to, rs);
        checks++;
        if (to || cyc != 7) begin errors++; $display("FAIL lat_cycle: got %0d (timeout=%0d) expected 7", cyc, to); end
        checks++;
        if (rs) begin errors++; $display("FAIL lat_rdy_calc: got rdy=1 during CALC expected 0"); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (ostream_result !== exp || exp !== 8'd4) begin
            errors++; $display("FAIL lat_result: got %0d expected 4", ostream_result);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
            errors++; $display("FAIL lat_idle: got rdy=%b val=%b expected rdy=1 val=0", istream_rdy, ostream_val);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_boundaries();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        int         tl[3];
        bit hs, to, rs; int cyc; logic [7:0] exp;
        ta = '{8'd5, 8'd0, 8'd0};
        tb = '{8'd0, 8'd9, 8'd0};
        tl = '{2, 3, 2};
        ostream_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ta[i], tb[i], hs);
            wait_result(20, cyc, to, rs);
            checks++;
            if (to || cyc != tl[i]) begin
                errors++; $display("FAIL bound_lat_%0d: got %0d expected %0d", i, cyc, tl[i]);
            end
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            checks++;
            if (ostream_result !== exp) begin
                errors++; $display("FAIL bound_result_%0d: got %0d expected %0d", i, ostream_result, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_worst();
        bit hs, to, rs; int cyc; logic [7:0] exp;
        ostream_rdy = 1'b1;
        send(8'd255, 8'd1, hs);
        wait_result(300, cyc, to, rs);
        checks++;
        if (to || cyc != 258) begin errors++; $display("FAIL worst_lat: got %0d expected 258", cyc); end
        checks++;
        if (rs || istream_rdy !== 1'b0) begin errors++; $display("FAIL worst_rdy: got rdy high in cycles 1-258 expected low"); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (ostream_result !== exp || exp !== 8'd1) begin
            errors++; $display("FAIL worst_result: got %0d expected 1", ostream_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit hs, to, rs; int cyc; logic [7:0] exp;
        ostream_rdy = 1'b0;
        send(8'd48, 8'd18, hs);
        wait_result(100, cyc, to, rs);
        checks++;
        if (to) begin errors++; $display("FAIL stall_timeout: got no result expected result 6"); end
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (ostream_result !== exp || exp !== 8'd6) begin
            errors++; $display("FAIL stall_result: got %0d expected 6", ostream_result);
        end
        istream_a = 8'd7; istream_b = 8'd7; istream_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (ostream_val !== 1'b1 || ostream_result !== 8'd6 || istream_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: got val=%b res=%0d rdy=%b expected val=1 res=6 rdy=0",
                         i, ostream_val, ostream_result, istream_rdy);
            end
        end
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
            errors++; $display("FAIL stall_accept: got rdy=%b val=%b expected rdy=1 val=0", istream_rdy, ostream_val);
        end
        if (istream_rdy) sb.push_back(ref_gcd(8'd7, 8'd7));
        @(posedge clk); #1;
        istream_val = 1'b0;
        wait_result(20, cyc, to, rs);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (to || ostream_result !== exp || exp !== 8'd7) begin
            errors++; $display("FAIL stall_second: got %0d expected 7", ostream_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit hs, to, rs; int cyc; logic [7:0] exp;
        ostream_rdy = 1'b1;
        send(8'd200, 8'd3, hs);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (ostream_val !== 1'b0) begin errors++; $display("FAIL rmid_early_val: got 1 expected 0 at cycle %0d", c); end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_result !== 8'd0) begin
            errors++;
            $display("FAIL rmid_idle: got rdy=%b val=%b res=%0d expected rdy=1 val=0 res=0",
                     istream_rdy, ostream_val, ostream_result);
        end
        sb.delete();
        @(posedge clk); #1;
        send(8'd9, 8'd6, hs);
        wait_result(40, cyc, to, rs);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        checks++;
        if (to || ostream_result !== exp || exp !== 8'd3) begin
            errors++; $display("FAIL rmid_after: got %0d expected 3", ostream_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0;
        bit accepted, held;
        logic [7:0] held_val, exp;
        held = 0; held_val = 8'd0;
        istream_a = 8'($urandom); istream_b = 8'($urandom);
        istream_val = 1'b1;
        while (got < 1000 && cyc < 95000) begin
            ostream_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = 0;
            if (held) begin
                checks++;
                if (ostream_val !== 1'b1 || ostream_result !== held_val) begin
                    errors++; $display("FAIL b2b_stable: got val=%b res=%0d expected val=1 res=%0d",
                                       ostream_val, ostream_result, held_val);
                end
            end
            if (istream_val && istream_rdy) begin
                if (ostream_val) begin errors++; $display("FAIL b2b_overlap: got both handshakes expected one"); end
                sb.push_back(ref_gcd(istream_a, istream_b));
                sent++;
                accepted = 1;
            end
            held = ostream_val && !ostream_rdy;
            held_val = ostream_result;
            if (ostream_val && ostream_rdy) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                checks++;
                if (ostream_result !== exp) begin
                    errors++; $display("FAIL b2b_result_%0d: got %0d expected %0d", got, ostream_result, exp);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                case ($urandom_range(0, 9))
                    0: begin istream_a = 8'd0; istream_b = 8'($urandom); end
                    1: begin istream_a = 8'($urandom); istream_b = 8'd0; end
                    default: begin istream_a = 8'($urandom); istream_b = 8'($urandom); end
                endcase
                if (sent >= 1000) istream_val = 1'b0;
            end
        end
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        checks++;
        if (got != 1000 || sb.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d results (%0d pending) expected 1000 (0 pending)", got, sb.size());
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ostream_val !== 1'b0) begin errors++; $display("FAIL b2b_extra: got val=1 expected 0"); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; istream_val = 1'b0; istream_a = 8'd0; istream_b = 8'd0; ostream_rdy = 1'b1;
        test_reset();
        test_latency();
        test_boundaries();
        test_worst();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_unit_8b.md
GCD_UNIT_8B -- requirements
Module: gcd_unit_8b

Interface
REQ-001 Parameters SHALL be none; all datapath widths SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 istream_val  input  1  upstream operand pair valid.
REQ-005 istream_rdy  output  1  block can accept an operand pair.
REQ-006 istream_a  input  8  operand A, unsigned.
REQ-007 istream_b  input  8  operand B, unsigned.
REQ-008 ostream_val  output  1  result valid.
REQ-009 ostream_rdy  input  1  downstream can accept result.
REQ-010 ostream_result  output  8  gcd(A,B), unsigned.

Function
REQ-011 Control SHALL be an FSM with exactly three states: IDLE, CALC, DONE.
REQ-012 Datapath SHALL hold two 8-bit registers, A and B.
REQ-013 IDLE: istream_rdy=1, ostream_val=0; when istream_val=1, the edge SHALL load A<=istream_a, B<=istream_b and enter CALC.
REQ-014 CALC and DONE: istream_rdy SHALL be 0; istream_* SHALL be ignored.
REQ-015 CALC SHALL perform exactly one action per cycle, in this priority order: (a) A<B (unsigned): swap A and B; (b) otherwise, B!=0: A<=A-B; (c) otherwise (B==0): enter DONE with A and B unchanged.
REQ-016 A-B SHALL be computed by an instance of the team's gate-level 8-bit subtractor (Subtractor_8b_GL); the unsigned A<B compare SHALL be a separate 8-bit comparator.
REQ-017 No subtraction SHALL wrap: (b) executes only when A>=B.
REQ-018 DONE: ostream_val=1, ostream_result=A; A and B SHALL hold.
REQ-019 DONE with ostream_rdy=1 SHALL return to IDLE on that edge; with ostream_rdy=0, the FSM SHALL stay in DONE with ostream_result stable.
REQ-020 Outside DONE, ostream_result SHALL still drive A; consumers qualify it with ostream_val.
REQ-021 Boundaries: gcd(x,0)=x; gcd(0,x)=x after one swap; gcd(0,0)=0.
REQ-022 Latency: handshake in cycle 0; CALC occupies cycles 1..N, where N = swaps + subtractions + 1; ostream_val is first high in cycle N+1.
REQ-023 Worst case gcd(255,1) SHALL take N=257 CALC cycles; the block SHALL have no timeout.
REQ-024 Output and input handshakes SHALL never overlap: a new operand pair SHALL be accepted no earlier than the cycle after the result handshake.

Reset
REQ-025 rst_n=0 on a rising edge SHALL force state IDLE and A=0, B=0; outputs then read istream_rdy=1, ostream_val=0, ostream_result=0.
REQ-026 Reset asserted in CALC or DONE SHALL abandon the computation with no result emitted; the first operand pair after rst_n returns high SHALL be processed normally.
REQ-027 While rst_n=0, istream_val SHALL be ignored and no handshake SHALL occur.

Verification
REQ-028 Apply (12,8) with ostream_rdy=1 -> CALC for cycles 1-6; ostream_val=1 with ostream_result=4 in cycle 7; IDLE in cycle 8.
REQ-029 Apply (5,0), (0,9) and (0,0) -> results 5, 9 and 0; ostream_val first high in cycles 2, 3 and 2 respectively.
REQ-030 Apply (255,1) -> ostream_result=1 with ostream_val first high in cycle 258; istream_rdy=0 throughout cycles 1-258.
REQ-031 Apply (48,18) with ostream_rdy=0 for 5 cycles after ostream_val rises -> result 6 held stable while stalled; istream_val=1 with (7,7) during the stall is not accepted; after ostream_rdy=1, (7,7) is accepted and yields 7.
REQ-032 Apply (200,3); pulse rst_n=0 for one cycle at cycle 10 -> next cycle reads IDLE, istream_rdy=1, ostream_val=0, ostream_result=0; a following (9,6) yields 3.
REQ-033 Randomized: 1000 back-to-back random pairs with random ostream_rdy backpressure -> every result matches the reference gcd; no result is dropped or duplicated.
